// File: rtl/regfile_pkg.sv
// Shared constants, helper function and write-port bundle type for the
// multi-port register file slice.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  // Elaboration-time ceil(log2(value)), usable inside parameter lists.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  localparam int DEF_AW = clog2(DEF_NREGS);

  typedef struct packed {
    logic              we;
    logic [DEF_AW-1:0] wa;
    logic [DEF_XLEN-1:0] wd;
  } wr_port_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit vector: one bit per register, set on reservation and
// cleared on writeback, with a reservation beating a same-cycle clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS   = DEF_NREGS,
  parameter int NWR     = 1,
  parameter int AW      = clog2(NREGS),
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic [NREGS-1:0]  pend
);

  logic [NREGS-1:0] pend_next;

  // Clears are applied before the set so a new owner keeps the bit.
  always_comb begin
    pend_next = pend;
    for (int k = 0; k < NWR; k++) begin
      if (we[k]) pend_next[wa[k*AW +: AW]] = 1'b0;
    end
    if (rsv_en) pend_next[rsv_addr] = 1'b1;
    if (ZERO_R0) pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '0;
    end else begin
      pend <= pend_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NRD-read / NWR-write register file with optional
// write-to-read bypass and a per-register pending scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int NREGS   = DEF_NREGS,
  parameter int NRD     = 2,
  parameter int NWR     = 1,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b1,
  localparam int AW     = clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_pend,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NREGS-1:0]    pend_vec
);

  logic [XLEN-1:0] rf [NREGS];

  // Later ports overwrite earlier ones, so the highest port index wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) rf[r] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && !(ZERO_R0 && (wa[k*AW +: AW] == '0))) begin
          rf[wa[k*AW +: AW]] <= wd[k*XLEN +: XLEN];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .NWR     (NWR),
    .AW      (AW),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (we),
    .wa       (wa),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .pend     (pend_vec)
  );

  genvar i;
  for (i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            hit;

    assign addr = ra[i*AW +: AW];

    // A forwarded write also hides the pending bit it is about to clear.
    always_comb begin
      data = rf[addr];
      hit  = 1'b0;
      if (BYPASS) begin
        for (int k = 0; k < NWR; k++) begin
          if (we[k] && (wa[k*AW +: AW] == addr)) begin
            data = wd[k*XLEN +: XLEN];
            hit  = 1'b1;
          end
        end
      end
      if (ZERO_R0 && (addr == '0)) begin
        data = '0;
        hit  = 1'b0;
      end
    end

    assign rd[i*XLEN +: XLEN] = data;
    assign rd_pend[i]         = pend_vec[addr] && !hit;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: bypass and non-bypass instances share stimulus and are
// compared every cycle against an array-based model, plus literal pins.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 4;
  localparam int NWR   = 2;

  logic                clk;
  logic                reset_n;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic [NRD*AW-1:0]   ra;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic [NRD*XLEN-1:0] rd_b, rd_n;
  logic [NRD-1:0]      rd_pend_b, rd_pend_n;
  logic [NREGS-1:0]    pend_vec_b, pend_vec_n;

  logic [XLEN-1:0] m_rf [NREGS];
  bit              m_pend [NREGS];
  int              n_cmp;
  int              n_fail;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1), .ZERO_R0(1'b1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rd(rd_b), .rd_pend(rd_pend_b), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend_vec(pend_vec_b)
  );

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0), .ZERO_R0(1'b1)
  ) dut_n (
    .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rd(rd_n), .rd_pend(rd_pend_n), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend_vec(pend_vec_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_rf[r]   = '0;
      m_pend[r] = 1'b0;
    end
  endtask

  // Writes land first, then a reservation re-marks its register pending.
  task automatic model_commit();
    int a;
    if (!reset_n) return;
    for (int k = 0; k < NWR; k++) begin
      if (we[k]) begin
        a = int'(wa[k*AW +: AW]);
        if (a != 0) m_rf[a] = wd[k*XLEN +: XLEN];
        m_pend[a] = 1'b0;
      end
    end
    if (rsv_en && rsv_addr != '0) m_pend[rsv_addr] = 1'b1;
  endtask

  task automatic model_read(input int port, input bit byp,
                            output logic [XLEN-1:0] v, output logic p);
    int  a;
    bit  hit;
    a   = int'(ra[port*AW +: AW]);
    v   = m_rf[a];
    hit = 1'b0;
    if (byp) begin
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && int'(wa[k*AW +: AW]) == a) begin
          v   = wd[k*XLEN +: XLEN];
          hit = 1'b1;
        end
      end
    end
    p = m_pend[a] && !hit;
    if (a == 0) begin
      v = '0;
      p = 1'b0;
    end
  endtask

  task automatic compare(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    logic [XLEN-1:0]  v;
    logic             p;
    logic [NREGS-1:0] pv;
    for (int i = 0; i < NRD; i++) begin
      model_read(i, 1'b1, v, p);
      compare($sformatf("rd_b[%0d]", i), rd_b[i*XLEN +: XLEN], v);
      compare($sformatf("rd_pend_b[%0d]", i), {31'b0, rd_pend_b[i]}, {31'b0, p});
      model_read(i, 1'b0, v, p);
      compare($sformatf("rd_n[%0d]", i), rd_n[i*XLEN +: XLEN], v);
      compare($sformatf("rd_pend_n[%0d]", i), {31'b0, rd_pend_n[i]}, {31'b0, p});
    end
    for (int r = 0; r < NREGS; r++) pv[r] = m_pend[r];
    compare("pend_vec_b", pend_vec_b, pv);
    compare("pend_vec_n", pend_vec_n, pv);
  endtask

  task automatic eval_cycle();
    #2;
    if (!reset_n) model_reset();
    check_output();
  endtask

  task automatic commit_cycle();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [NWR-1:0] w, input int a0, input int a1,
                                input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                                input logic r, input int radr);
    we       = w;
    wa       = {AW'(a1), AW'(a0)};
    wd       = {d1, d0};
    rsv_en   = r;
    rsv_addr = AW'(radr);
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    ra      = '0;
    apply_stimulus(2'b00, 0, 0, '0, '0, 1'b0, 0);
    model_reset();
    @(negedge clk);
    eval_cycle();
    commit_cycle();
    reset_n = 1'b1;

    // T1: write r5, reserve it, then a mid-cycle reset wipes both.
    apply_stimulus(2'b01, 5, 0, 32'hDEAD_BEEF, '0, 1'b0, 0);
    ra = {5'd0, 5'd0, 5'd0, 5'd5};
    eval_cycle();
    compare("t1_bypass_r5", rd_b[0 +: XLEN], 32'hDEAD_BEEF);
    commit_cycle();
    apply_stimulus(2'b00, 0, 0, '0, '0, 1'b1, 5);
    eval_cycle();
    compare("t1_stored_r5", rd_b[0 +: XLEN], 32'hDEAD_BEEF);
    commit_cycle();
    apply_stimulus(2'b00, 0, 0, '0, '0, 1'b0, 0);
    eval_cycle();
    compare("t1_pend_r5", {31'b0, pend_vec_b[5]}, 32'd1);
    reset_n = 1'b0;
    eval_cycle();
    compare("t1_reset_r5", rd_b[0 +: XLEN], 32'h0);
    compare("t1_reset_pend", pend_vec_b, 32'h0);
    commit_cycle();
    reset_n = 1'b1;

    // T2: r0 ignores writes and reservations.
    apply_stimulus(2'b01, 0, 0, 32'h1234, '0, 1'b1, 0);
    ra = '0;
    eval_cycle();
    compare("t2_r0_same", rd_b[0 +: XLEN], 32'h0);
    compare("t2_r0_pend_same", {31'b0, rd_pend_b[0]}, 32'h0);
    commit_cycle();
    apply_stimulus(2'b00, 0, 0, '0, '0, 1'b0, 0);
    eval_cycle();
    compare("t2_r0_next", rd_b[0 +: XLEN], 32'h0);
    compare("t2_pend_vec0", {31'b0, pend_vec_b[0]}, 32'h0);

    // T3: bypass versus stored read of r7.
    apply_stimulus(2'b01, 7, 0, 32'hA5A5_0001, '0, 1'b0, 0);
    ra = {5'd0, 5'd0, 5'd7, 5'd0};
    eval_cycle();
    compare("t3_bypass", rd_b[XLEN +: XLEN], 32'hA5A5_0001);
    compare("t3_nobypass_old", rd_n[XLEN +: XLEN], 32'h0);
    commit_cycle();
    apply_stimulus(2'b00, 0, 0, '0, '0, 1'b0, 0);
    eval_cycle();
    compare("t3_nobypass_new", rd_n[XLEN +: XLEN], 32'hA5A5_0001);

    // T4: both write ports hit r3, port 1 wins.
    apply_stimulus(2'b11, 3, 3, 32'h11, 32'h22, 1'b0, 0);
    ra = {5'd0, 5'd3, 5'd0, 5'd0};
    eval_cycle();
    compare("t4_bypass_prio", rd_b[2*XLEN +: XLEN], 32'h22);
    commit_cycle();
    apply_stimulus(2'b00, 0, 0, '0, '0, 1'b0, 0);
    eval_cycle();
    compare("t4_stored_prio", rd_n[2*XLEN +: XLEN], 32'h22);

    // T5: scoreboard set, clear, and set-beats-clear on r9.
    apply_stimulus(2'b00, 0, 0, '0, '0, 1'b1, 9);
    ra = {5'd9, 5'd0, 5'd0, 5'd0};
    eval_cycle();
    commit_cycle();
    apply_stimulus(2'b00, 0, 0, '0, '0, 1'b0, 0);
    eval_cycle();
    compare("t5_pend_b", {31'b0, rd_pend_b[3]}, 32'd1);
    compare("t5_pend_n", {31'b0, rd_pend_n[3]}, 32'd1);
    apply_stimulus(2'b01, 9, 0, 32'h99, '0, 1'b0, 0);
    eval_cycle();
    compare("t5_pend_hidden_b", {31'b0, rd_pend_b[3]}, 32'd0);
    compare("t5_pend_kept_n", {31'b0, rd_pend_n[3]}, 32'd1);
    commit_cycle();
    apply_stimulus(2'b00, 0, 0, '0, '0, 1'b0, 0);
    eval_cycle();
    compare("t5_cleared", {31'b0, pend_vec_b[9]}, 32'd0);
    apply_stimulus(2'b10, 0, 9, '0, 32'h77, 1'b1, 9);
    eval_cycle();
    commit_cycle();
    apply_stimulus(2'b00, 0, 0, '0, '0, 1'b0, 0);
    eval_cycle();
    compare("t5_set_wins", {31'b0, pend_vec_b[9]}, 32'd1);
    commit_cycle();

    // T6: randomised traffic with narrow address ranges for collisions.
    for (int c = 0; c < 2000; c++) begin
      reset_n = ($urandom_range(0, 63) != 0);
      apply_stimulus(2'($urandom_range(0, 3)),
                     $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31),
                     $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31),
                     $urandom, $urandom,
                     1'($urandom_range(0, 1)),
                     $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      for (int i = 0; i < NRD; i++) begin
        ra[i*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      end
      eval_cycle();
      commit_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
